// File: rtl/router_pkt_writer.sv
// Router input-side packet writer: validates the header address, steers bytes into
// one of three output FIFOs through a one-entry hold register, and checks trailing parity.
module router_pkt_writer (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [7:0] data_in,
   input  logic [2:0] fifo_full,
   output logic       busy,
   output logic [2:0] wr_en,
   output logic       lfd_state,
   output logic [7:0] dout,
   output logic       pkt_done,
   output logic       parity_err,
   output logic       drop
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_PARITY,
      S_DROP
   } state_t;

   state_t     r_state;
   logic [7:0] r_hold_data;
   logic       r_hold_lfd;
   logic       r_hold_vld;
   logic [1:0] r_dest;
   logic [5:0] r_rem;
   logic [7:0] r_par;
   logic [6:0] r_drop_cnt;
   logic       r_pkt_done;
   logic       r_parity_err;
   logic       r_drop;

   logic       w_full_dest;
   logic       w_busy;
   logic       w_accept;
   logic       w_write;
   logic       w_hdr_drop;
   logic       w_load;

   // r_dest is only ever loaded from a valid address, so index 3 never occurs
   always_comb begin
      case (r_dest)
         2'd0:    w_full_dest = fifo_full[0];
         2'd1:    w_full_dest = fifo_full[1];
         default: w_full_dest = fifo_full[2];
      endcase
   end

   assign w_busy     = r_hold_vld & w_full_dest;
   assign w_accept   = pkt_valid & ~w_busy;
   assign w_write    = r_hold_vld & ~w_full_dest;
   assign w_hdr_drop = (r_state == S_IDLE) && (data_in[1:0] == 2'd3);
   assign w_load     = w_accept && (r_state != S_DROP) && !w_hdr_drop;

   always_comb begin
      wr_en = 3'b000;
      if (w_write) begin
         case (r_dest)
            2'd0:    wr_en = 3'b001;
            2'd1:    wr_en = 3'b010;
            default: wr_en = 3'b100;
         endcase
      end
   end

   assign busy       = w_busy;
   assign dout       = r_hold_data;
   assign lfd_state  = r_hold_lfd & r_hold_vld;
   assign pkt_done   = r_pkt_done;
   assign parity_err = r_parity_err;
   assign drop       = r_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hold_data  <= 8'h00;
         r_hold_lfd   <= 1'b0;
         r_hold_vld   <= 1'b0;
         r_dest       <= 2'd0;
         r_rem        <= 6'd0;
         r_par        <= 8'h00;
         r_drop_cnt   <= 7'd0;
         r_pkt_done   <= 1'b0;
         r_parity_err <= 1'b0;
         r_drop       <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         r_drop     <= 1'b0;

         // A reload in the same cycle as a write keeps the stream bubble-free
         if (w_load) begin
            r_hold_data <= data_in;
            r_hold_vld  <= 1'b1;
            r_hold_lfd  <= (r_state == S_IDLE);
         end else if (w_write) begin
            r_hold_vld  <= 1'b0;
         end

         if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (w_hdr_drop) begin
                     r_drop_cnt <= {1'b0, data_in[7:2]} + 7'd1;
                     r_state    <= S_DROP;
                  end else begin
                     r_dest       <= data_in[1:0];
                     r_rem        <= data_in[7:2];
                     r_par        <= data_in;
                     r_parity_err <= 1'b0;
                     r_state      <= (data_in[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  r_par <= r_par ^ data_in;
                  r_rem <= r_rem - 6'd1;
                  if (r_rem == 6'd1) r_state <= S_PARITY;
               end
               S_PARITY: begin
                  r_pkt_done   <= 1'b1;
                  r_parity_err <= (data_in != r_par);
                  r_state      <= S_IDLE;
               end
               default: begin
                  r_drop_cnt <= r_drop_cnt - 7'd1;
                  if (r_drop_cnt == 7'd1) begin
                     r_drop  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_writer.sv
// Bench for router_pkt_writer: directed packets with literal expectations plus a
// randomized packet stream checked every cycle against a packet-level model.
module tb_router_pkt_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic       busy;
   logic [2:0] wr_en;
   logic       lfd_state;
   logic [7:0] dout;
   logic       pkt_done;
   logic       parity_err;
   logic       drop;

   router_pkt_writer dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_valid  (pkt_valid),
      .data_in    (data_in),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .wr_en      (wr_en),
      .lfd_state  (lfd_state),
      .dout       (dout),
      .pkt_done   (pkt_done),
      .parity_err (parity_err),
      .drop       (drop)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // ---------------- packet-level reference model ----------------
   typedef struct { int fifo; int d; int lfd; int cyc; } wr_t;
   wr_t exp_q[$];
   wr_t wlog[$];

   int         m_left = 0;
   bit         m_is_drop = 0;
   int         m_dest = 0;
   logic [7:0] m_par = 8'h00;
   int         e_perr = 0;
   int         e_done, e_drop;

   bit         acc_now = 0;
   logic [7:0] acc_byte;
   bit         rand_full = 0;
   int         cyc = 0, n_done = 0, n_drop = 0, n_busy = 0;

   task automatic model_accept(input logic [7:0] b);
      wr_t w;
      if (m_left == 0) begin
         m_left = int'(b[7:2]) + 1;
         if (b[1:0] == 2'd3) m_is_drop = 1;
         else begin
            m_is_drop = 0;
            m_dest    = int'(b[1:0]);
            m_par     = b;
            e_perr    = 0;
            w.fifo = m_dest; w.d = int'(b); w.lfd = 1; w.cyc = 0;
            exp_q.push_back(w);
         end
      end else begin
         m_left--;
         if (m_is_drop) begin
            if (m_left == 0) e_drop = 1;
         end else begin
            w.fifo = m_dest; w.d = int'(b); w.lfd = 0; w.cyc = 0;
            exp_q.push_back(w);
            if (m_left == 0) begin
               e_done = 1;
               e_perr = (b != m_par) ? 1 : 0;
            end else m_par = m_par ^ b;
         end
      end
   endtask

   // Compare process: outputs sampled 2 time units after each rising edge
   initial begin
      wr_t a;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (wr_en != 3'b000) begin
            a.fifo = (wr_en == 3'b001) ? 0 : (wr_en == 3'b010) ? 1 : 2;
            a.d = int'(dout); a.lfd = int'(lfd_state); a.cyc = cyc;
            wlog.push_back(a);
         end
         n_done += int'(pkt_done);
         n_drop += int'(drop);
         n_busy += int'(busy);
         if (rst) begin
            exp_q.delete();
            m_left = 0; e_perr = 0; acc_now = 0;
            chk("rst_wr_en", int'(wr_en), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_lfd", int'(lfd_state), 0);
            chk("rst_dout", int'(dout), 0);
            chk("rst_flags", int'({pkt_done, parity_err, drop}), 0);
         end else begin
            e_done = 0; e_drop = 0;
            if (acc_now) begin
               model_accept(acc_byte);
               acc_now = 0;
            end
            chk("pkt_done", int'(pkt_done), e_done);
            chk("drop", int'(drop), e_drop);
            chk("parity_err", int'(parity_err), e_perr);
            if (exp_q.size() > 0) begin
               chk("busy", int'(busy), int'(fifo_full[exp_q[0].fifo]));
               if (!fifo_full[exp_q[0].fifo]) begin
                  chk("wr_en", int'(wr_en), 1 << exp_q[0].fifo);
                  chk("dout", int'(dout), exp_q[0].d);
                  chk("lfd_state", int'(lfd_state), exp_q[0].lfd);
                  void'(exp_q.pop_front());
               end else chk("wr_en_full", int'(wr_en), 0);
            end else begin
               chk("busy_idle", int'(busy), 0);
               chk("wr_en_idle", int'(wr_en), 0);
               chk("lfd_idle", int'(lfd_state), 0);
            end
         end
      end
   end

   // Random FIFO-full pattern, changed just after the edge so it is stable for a whole cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_full) fifo_full = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      end
   end

   // ---------------- driver ----------------
   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      pkt_valid = 1'b1;
      data_in   = b;
      #4;
      while (busy && k < 500) begin
         @(negedge clk);
         #4;
         k++;
      end
      if (busy) chk("send_timeout", 1, 0);
      else begin
         acc_byte = b;
         acc_now  = 1;
      end
      @(negedge clk);
      pkt_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_log(input int n);
      int k = 0;
      while (wlog.size() < n && k < 200) begin
         @(posedge clk);
         #3;
         k++;
      end
      if (wlog.size() < n) chk("wait_log_timeout", wlog.size(), n);
   endtask

   logic [7:0] e1 [5];
   logic [7:0] e5 [5];
   int         d0, d1, d2;

   initial begin
      rst = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
      #1;
      chk("por_outputs", int'({busy, wr_en, lfd_state, dout, pkt_done, parity_err, drop}), 0);
      idle(2);
      rst = 1'b0;
      idle(1);

      // 1: L=3 to FIFO 1, good parity
      e1 = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      wlog.delete(); d0 = n_done;
      for (int i = 0; i < 5; i++) send_byte(e1[i]);
      idle(3);
      chk("t1_nwr", wlog.size(), 5);
      for (int i = 0; i < 5 && i < wlog.size(); i++) begin
         chk("t1_data", wlog[i].d, int'(e1[i]));
         chk("t1_fifo", wlog[i].fifo, 1);
         chk("t1_lfd", wlog[i].lfd, (i == 0) ? 1 : 0);
         chk("t1_back2back", wlog[i].cyc - wlog[0].cyc, i);
      end
      chk("t1_done", n_done - d0, 1);
      chk("t1_perr", int'(parity_err), 0);

      // 2: same packet, bad parity
      wlog.delete();
      for (int i = 0; i < 4; i++) send_byte(e1[i]);
      send_byte(8'hFF);
      idle(4);
      chk("t2_nwr", wlog.size(), 5);
      if (wlog.size() == 5) chk("t2_last", wlog[4].d, 8'hFF);
      chk("t2_perr_held", int'(parity_err), 1);

      // 3: L=0 to FIFO 0
      wlog.delete(); d0 = n_done;
      send_byte(8'h00); send_byte(8'h00);
      idle(3);
      chk("t3_nwr", wlog.size(), 2);
      if (wlog.size() == 2) chk("t3_fifo", wlog[0].fifo + wlog[1].fifo, 0);
      chk("t3_done", n_done - d0, 1);
      chk("t3_perr", int'(parity_err), 0);

      // 4: address-3 packet dropped, then next byte is a header
      wlog.delete(); d1 = n_drop;
      send_byte(8'h0B); send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
      idle(2);
      chk("t4_no_wr", wlog.size(), 0);
      chk("t4_drop", n_drop - d1, 1);
      send_byte(8'h05); send_byte(8'h77); send_byte(8'h72);
      idle(3);
      chk("t4_next_nwr", wlog.size(), 3);
      if (wlog.size() > 0) chk("t4_next_hdr", wlog[0].d + 256 * wlog[0].lfd, 256 + 8'h05);

      // 5: FIFO 2 full for 4 cycles mid-payload
      e5 = '{8'h0E, 8'hA1, 8'hA2, 8'hA3, 8'h0E ^ 8'hA1 ^ 8'hA2 ^ 8'hA3};
      wlog.delete(); d2 = n_busy;
      fork
         for (int i = 0; i < 5; i++) send_byte(e5[i]);
         begin
            wait_log(2);
            @(posedge clk); #1; fifo_full[2] = 1'b1;
            repeat (4) @(posedge clk);
            #1; fifo_full[2] = 1'b0;
         end
      join
      idle(3);
      chk("t5_busy_cycles", n_busy - d2, 4);
      chk("t5_nwr", wlog.size(), 5);
      for (int i = 0; i < 5 && i < wlog.size(); i++) chk("t5_data", wlog[i].d, int'(e5[i]));
      if (wlog.size() == 5) chk("t5_stall_gap", wlog[2].cyc - wlog[1].cyc, 5);

      // 6: reset mid-packet
      send_byte(8'h15); send_byte(8'h01); send_byte(8'h02);
      #2; rst = 1'b1;
      #1;
      chk("t6_async_rst", int'({busy, wr_en, lfd_state, dout, pkt_done, parity_err, drop}), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      wlog.delete();
      send_byte(8'h09); send_byte(8'h55); send_byte(8'h66); send_byte(8'h09 ^ 8'h55 ^ 8'h66);
      idle(3);
      chk("t6_nwr", wlog.size(), 4);
      if (wlog.size() > 0) chk("t6_hdr", wlog[0].d + 256 * wlog[0].lfd + 1024 * wlog[0].fifo, 1024 + 256 + 8'h09);

      // Random stream with random back-pressure
      rand_full = 1;
      for (int p = 0; p < 150; p++) begin
         logic [5:0] l6;
         logic [1:0] dd;
         logic [7:0] hdr, par, b;
         l6 = 6'($urandom_range(0, 12));
         dd = 2'($urandom_range(0, 3));
         hdr = {l6, dd};
         par = hdr;
         send_byte(hdr);
         for (int i = 0; i < int'(l6); i++) begin
            b = 8'($urandom);
            par = par ^ b;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_byte(b);
         end
         if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
         send_byte(par);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      rand_full = 0;
      @(posedge clk); #1; fifo_full = 3'b000;
      idle(5);
      chk("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
